// File: rtl/seg_scan_driver_pkg.sv
// rtl/seg_scan_driver_pkg.sv - shared defaults, scan state enum and hex segment table
package seg_scan_driver_pkg;

  localparam int DEFAULT_DIGITS         = 4;
  localparam bit DEFAULT_SEG_ACTIVE_LOW = 1'b1;
  localparam bit DEFAULT_AN_ACTIVE_LOW  = 1'b1;

  typedef enum logic {
    SCAN  = 1'b0,
    BLANK = 1'b1
  } scan_state_e;

  // Active-high {g,f,e,d,c,b,a} patterns for 0..F
  localparam logic [0:15][6:0] HEX_SEG = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_to_7seg.sv
// rtl/hex_to_7seg.sv - combinational hex nibble to active-high seven-segment decode
module hex_to_7seg
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed seven-segment scanner with frame-aligned shadow data
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int DIGITS         = DEFAULT_DIGITS,
  parameter bit SEG_ACTIVE_LOW = DEFAULT_SEG_ACTIVE_LOW,
  parameter bit AN_ACTIVE_LOW  = DEFAULT_AN_ACTIVE_LOW
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{AN_ACTIVE_LOW}};
  localparam logic [6:0]        SEG_OFF  = {7{SEG_ACTIVE_LOW}};

  scan_state_e           state, state_n;
  logic [IDX_W-1:0]      idx, idx_n;
  logic [4*DIGITS-1:0]   shadow, disp, disp_n;
  logic [DIGITS-1:0]     shadow_dp, disp_dp, disp_dp_n;
  logic                  frame;

  logic [3:0]            nib;
  logic [6:0]            dec;
  logic                  scan_n, lz_blank;
  logic [DIGITS-1:0]     an_hi;
  logic [6:0]            seg_hi;
  logic                  dp_hi;

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    frame     = 1'b0;
    case (state)
      SCAN:  if (tick) state_n = BLANK;
      BLANK: begin
        state_n = SCAN;
        idx_n   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        frame   = (idx_n == '0);
      end
      default: state_n = BLANK;
    endcase
    disp_n    = disp;
    disp_dp_n = disp_dp;
    // A load landing on the frame-copy clock bypasses the shadow so it shows this frame
    if (frame) begin
      disp_n    = load ? data_in : shadow;
      disp_dp_n = load ? dp_in   : shadow_dp;
    end
  end

  hex_to_7seg u_dec (
    .hex (nib),
    .seg (dec)
  );

  // Output flops are fed from next-state values so they move with the state
  always_comb begin
    nib      = 4'(disp_n >> (4 * idx_n));
    scan_n   = (state_n == SCAN);
    lz_blank = blank_lz && (idx_n != '0) && ((disp_n >> (4 * idx_n)) == '0);
    an_hi    = scan_n ? (DIGITS'(1) << idx_n) : '0;
    seg_hi   = (scan_n && !lz_blank) ? dec : 7'h00;
    dp_hi    = scan_n && disp_dp_n[idx_n];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= BLANK;
      idx         <= LAST_IDX;
      shadow      <= '0;
      shadow_dp   <= '0;
      disp        <= '0;
      disp_dp     <= '0;
      anode       <= AN_OFF;
      seg         <= SEG_OFF;
      dp          <= SEG_ACTIVE_LOW;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      disp        <= disp_n;
      disp_dp     <= disp_dp_n;
      if (load) begin
        shadow    <= data_in;
        shadow_dp <= dp_in;
      end
      anode       <= an_hi ^ AN_OFF;
      seg         <= seg_hi ^ SEG_OFF;
      dp          <= dp_hi ^ SEG_ACTIVE_LOW;
      frame_start <= frame;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - directed self-checking bench for seg_scan_driver
module tb_seg_scan_driver;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int checks = 0;
  int failures = 0;

  // Active-low segment patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] S_OFF = 7'b1111111;
  localparam logic [6:0] S_0 = 7'b1000000;
  localparam logic [6:0] S_1 = 7'b1111001;
  localparam logic [6:0] S_2 = 7'b0100100;
  localparam logic [6:0] S_3 = 7'b0110000;
  localparam logic [6:0] S_4 = 7'b0011001;
  localparam logic [6:0] S_5 = 7'b0010010;
  localparam logic [6:0] S_A = 7'b0001000;
  localparam logic [6:0] S_B = 7'b0000011;
  localparam logic [6:0] S_C = 7'b1000110;
  localparam logic [6:0] S_D = 7'b0100001;

  seg_scan_driver dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .load        (load),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .blank_lz    (blank_lz),
    .anode       (anode),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_digit(input string tag, input logic [3:0] an, input logic [6:0] sg,
                             input logic d, input logic fs);
    check_eq({tag, "_anode"}, 32'(anode), 32'(an));
    check_eq({tag, "_seg"}, 32'(seg), 32'(sg));
    check_eq({tag, "_dp"}, 32'(dp), 32'(d));
    check_eq({tag, "_fs"}, 32'(frame_start), 32'(fs));
  endtask

  // Idle a few clocks, tick once, verify the blank clock, land on the next digit
  task automatic advance(input string tag);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq({tag, "_hold"}, 32'(frame_start), 32'd0);
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    check_eq({tag, "_blank_an"}, 32'(anode), 32'hF);
    check_eq({tag, "_blank_seg"}, 32'(seg), 32'(S_OFF));
    check_eq({tag, "_blank_dp"}, 32'(dp), 32'd1);
    step();
  endtask

  initial begin
    step();
    step();
    check_digit("rst", 4'hF, S_OFF, 1'b1, 1'b0);
    reset = 1'b1;
    step();
    check_digit("first", 4'hE, S_0, 1'b1, 1'b1);
    data_in = 16'h1234;
    load = 1'b1;
    step();
    load = 1'b0;
    check_digit("f1d0", 4'hE, S_0, 1'b1, 1'b0);
    advance("f1d1"); check_digit("f1d1", 4'hD, S_0, 1'b1, 1'b0);
    advance("f1d2"); check_digit("f1d2", 4'hB, S_0, 1'b1, 1'b0);
    advance("f1d3"); check_digit("f1d3", 4'h7, S_0, 1'b1, 1'b0);
    advance("f2d0"); check_digit("f2d0", 4'hE, S_4, 1'b1, 1'b1);
    advance("f2d1"); check_digit("f2d1", 4'hD, S_3, 1'b1, 1'b0);
    advance("f2d2"); check_digit("f2d2", 4'hB, S_2, 1'b1, 1'b0);
    advance("f2d3"); check_digit("f2d3", 4'h7, S_1, 1'b1, 1'b0);
    advance("f3d0"); check_digit("f3d0", 4'hE, S_4, 1'b1, 1'b1);
    // A tick held through BLANK must not stretch the blank
    tick = 1'b1;
    step();
    check_eq("tb_blank_an", 32'(anode), 32'hF);
    step();
    tick = 1'b0;
    check_digit("f3d1", 4'hD, S_3, 1'b1, 1'b0);
    advance("f3d2"); check_digit("f3d2", 4'hB, S_2, 1'b1, 1'b0);
    data_in = 16'hABCD;
    load = 1'b1;
    step();
    load = 1'b0;
    check_digit("mid", 4'hB, S_2, 1'b1, 1'b0);
    advance("f3d3"); check_digit("f3d3", 4'h7, S_1, 1'b1, 1'b0);
    advance("f4d0"); check_digit("f4d0", 4'hE, S_D, 1'b1, 1'b1);
    advance("f4d1"); check_digit("f4d1", 4'hD, S_C, 1'b1, 1'b0);
    advance("f4d2"); check_digit("f4d2", 4'hB, S_B, 1'b1, 1'b0);
    advance("f4d3"); check_digit("f4d3", 4'h7, S_A, 1'b1, 1'b0);
    // Load on the frame-copy clock with leading-zero blanking
    blank_lz = 1'b1;
    tick = 1'b1;
    step();
    tick = 1'b0;
    data_in = 16'h00A5;
    load = 1'b1;
    step();
    load = 1'b0;
    check_digit("byp_d0", 4'hE, S_5, 1'b1, 1'b1);
    advance("byp_d1"); check_digit("byp_d1", 4'hD, S_A, 1'b1, 1'b0);
    advance("byp_d2"); check_digit("byp_d2", 4'hB, S_OFF, 1'b1, 1'b0);
    advance("byp_d3"); check_digit("byp_d3", 4'h7, S_OFF, 1'b1, 1'b0);
    data_in = 16'h0000;
    dp_in = 4'b0100;
    load = 1'b1;
    step();
    load = 1'b0;
    dp_in = 4'b0000;
    advance("dp_d0"); check_digit("dp_d0", 4'hE, S_0, 1'b1, 1'b1);
    advance("dp_d1"); check_digit("dp_d1", 4'hD, S_OFF, 1'b1, 1'b0);
    advance("dp_d2"); check_digit("dp_d2", 4'hB, S_OFF, 1'b0, 1'b0);
    advance("dp_d3"); check_digit("dp_d3", 4'h7, S_OFF, 1'b1, 1'b0);
    // Asynchronous reset while digit 3 is lit
    #2;
    reset = 1'b0;
    #1;
    check_digit("arst", 4'hF, S_OFF, 1'b1, 1'b0);
    step();
    check_digit("arst_hold", 4'hF, S_OFF, 1'b1, 1'b0);
    reset = 1'b1;
    step();
    check_digit("restart", 4'hE, S_0, 1'b1, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
